output_row_mem: RTL
===================

OUTPUT_ROW_MEM -- requirements
Module: output_row_mem

Interface
REQ-001 Parameter ROWS, default 4: output matrix rows, one memory word each.
REQ-002 Parameter COLS, default 4: output matrix columns packed per word.
REQ-003 Parameter WORD_SIZE, default 16: signed element width.
REQ-004 Parameter MEM_ACCESS_LATENCY, default 2: cycles from request to commit or read data.
REQ-005 Port clk input 1: the single clock; all logic on its rising edge.
REQ-006 Port rst_n input 1: reset, synchronous and active-low.
REQ-007 Port mem_wr_en input 1: write request strobe from the output-control stage.
REQ-008 Port mem_addr input 32: byte address of the row being written.
REQ-009 Port mem_data input MEM_PORT_WIDTH: packed row, col c at bits [c*WORD_SIZE +: WORD_SIZE].
REQ-010 Port rd_en input 1: host read request.
REQ-011 Port rd_row input $clog2(ROWS)+1: row index to read.
REQ-012 Port rd_data output MEM_PORT_WIDTH: read data.
REQ-013 Port rd_valid output 1: rd_data valid this cycle.
REQ-014 Port clear input 1: clears row-written bitmap and error flags; storage contents untouched.
REQ-015 Port rows_written output ROWS: bit r set once row r has committed.
REQ-016 Port all_rows_done output 1: high while rows_written is all ones.
REQ-017 Port wr_err output 1: sticky, set by any dropped write.
REQ-018 Port rd_err output 1: sticky, set by any read with rd_row >= ROWS.

Function
REQ-019 A write SHALL decode row = (mem_addr - OUTPUT_MAT_BASE_ADDR) / MEM_ADDR_INCR.
REQ-020 Address below base, not a multiple of MEM_ADDR_INCR above base, or row >= ROWS SHALL drop the write and set wr_err the cycle after mem_wr_en.
REQ-021 Valid writes SHALL pass a MEM_ACCESS_LATENCY-deep pipeline of (valid, row, data) and commit to storage and rows_written exactly MEM_ACCESS_LATENCY cycles after the mem_wr_en cycle.
REQ-022 A write SHALL be accepted every cycle, back-to-back, with no backpressure.
REQ-023 Two writes to the same row SHALL commit in issue order; the later data persists.
REQ-024 Reads SHALL be pipelined, one per cycle; rd_valid and rd_data appear exactly MEM_ACCESS_LATENCY cycles after rd_en.
REQ-025 Storage SHALL be sampled at the rd_en cycle; a write committing to the same row in that same cycle SHALL be forwarded (write-first); writes still in the pipeline SHALL NOT be visible.
REQ-026 A read with rd_row >= ROWS SHALL return rd_valid with rd_data zero and set rd_err.
REQ-027 rd_data SHALL be zero whenever rd_valid is low.
REQ-028 A commit in the same cycle as clear SHALL leave that row's bit set; clear wins over error-flag set in the same cycle.
REQ-029 all_rows_done SHALL be combinational from rows_written.

Reset
REQ-030 While rst_n is low at a clock edge, SHALL clear both pipelines, rows_written, wr_err, rd_err, rd_valid and rd_data.
REQ-031 Reset SHALL discard in-flight writes and reads mid-operation; storage SHALL be zeroed.

Structure
REQ-032 MEM_PORT_WIDTH, OUTPUT_MAT_BASE_ADDR and MEM_ADDR_INCR SHALL come from the shared header, not redefined locally.
REQ-033 The generic (valid, payload) delay line SHALL be one sub-module, latency_pipe, instanced for write and read paths.

Verification
REQ-034 Four writes, rows 0-3, data 0x1111..0x4444, latency 2 -> rows_written 0001,0011,0111,1111 on cycles 2-5; all_rows_done at cycle 5.
REQ-035 Write mem_addr = base+1 -> no commit, wr_err=1 next cycle, rows_written unchanged.
REQ-036 Write row 2 data 0xAAAA at t, rd_en row 2 at t+2 -> rd_data 0xAAAA at t+4; rd_en at t+1 -> old data.
REQ-037 rd_row=4 with ROWS=4 -> rd_valid with rd_data 0, rd_err=1; clear next cycle -> rd_err=0.
REQ-038 rst_n low one cycle between a write issue and its commit -> no commit, rows_written 0, storage 0.
REQ-039 clear coincident with row 1 commit -> rows_written = 0010 afterwards.

Source files
------------

// File: rtl/output_row_mem_pkg.sv
// Shared definitions for the output row memory: port width, address map
// and the write-address classification used by the write decoder.
package output_row_mem_pkg;

  localparam int          MEM_PORT_WIDTH       = 64;
  localparam logic [31:0] OUTPUT_MAT_BASE_ADDR = 32'h0000_1000;
  localparam logic [31:0] MEM_ADDR_INCR        = 32'd8;

  typedef enum logic [1:0] {
    ADDR_OK,
    ADDR_BELOW,
    ADDR_MISALIGNED,
    ADDR_OOR
  } addr_chk_e;

  // Classify a write byte address against the output-matrix window.
  function automatic addr_chk_e check_addr(input logic [31:0] addr,
                                           input logic [31:0] rows);
    logic [31:0] off;
    off = addr - OUTPUT_MAT_BASE_ADDR;
    if (addr < OUTPUT_MAT_BASE_ADDR)          return ADDR_BELOW;
    if ((off % MEM_ADDR_INCR) != 32'd0)       return ADDR_MISALIGNED;
    if ((off / MEM_ADDR_INCR) >= rows)        return ADDR_OOR;
    return ADDR_OK;
  endfunction

endpackage

// File: rtl/output_row_mem_latency_pipe.sv
// Fixed-depth (valid, payload) delay line; output is the last register.
module latency_pipe #(
  parameter int STAGES = 2,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][W-1:0] dat_pipe;

  assign vld_pipe[0] = in_vld;
  assign dat_pipe[0] = in_data;

  // Shift valid and payload one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      dat_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      dat_pipe[STAGES:1] <= dat_pipe[STAGES-1:0];
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/output_row_mem.sv
// Output matrix row store: latency-matched write commit path, pipelined
// host reads with write-first forwarding, row-written bitmap, sticky errors.
module output_row_mem
  import output_row_mem_pkg::*;
#(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int WORD_SIZE          = 16,
  parameter int MEM_ACCESS_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_wr_en,
  input  logic [31:0]               mem_addr,
  input  logic [MEM_PORT_WIDTH-1:0] mem_data,
  input  logic                      rd_en,
  input  logic [$clog2(ROWS):0]     rd_row,
  output logic [MEM_PORT_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      clear,
  output logic [ROWS-1:0]           rows_written,
  output logic                      all_rows_done,
  output logic                      wr_err,
  output logic                      rd_err
);

  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RD_W   = $clog2(ROWS) + 1;
  localparam logic [RD_W-1:0] ROWS_LIM = RD_W'(ROWS);

  // Element c of a row sits at bits [c*WORD_SIZE +: WORD_SIZE].
  typedef logic [COLS-1:0][WORD_SIZE-1:0] row_t;

  typedef struct packed {
    logic [RIDX_W-1:0] row;
    row_t              data;
  } wr_req_t;

  row_t [ROWS-1:0] mem;

  // ---------------- write path ----------------
  addr_chk_e   wr_chk;
  logic        wr_ok, wr_drop;
  wr_req_t     wr_in, wr_out;
  logic        wr_out_vld;
  logic [ROWS-1:0] commit_mask;

  assign wr_chk     = check_addr(mem_addr, 32'(ROWS));
  assign wr_ok      = mem_wr_en && (wr_chk == ADDR_OK);
  assign wr_drop    = mem_wr_en && (wr_chk != ADDR_OK);
  assign wr_in.row  = RIDX_W'((mem_addr - OUTPUT_MAT_BASE_ADDR) / MEM_ADDR_INCR);
  assign wr_in.data = mem_data;

  latency_pipe #(.STAGES(MEM_ACCESS_LATENCY), .W($bits(wr_req_t))) u_wr_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (wr_ok),
    .in_data  (wr_in),
    .out_vld  (wr_out_vld),
    .out_data (wr_out)
  );

  // One-hot of the row committing this cycle (empty when no commit).
  always_comb begin
    commit_mask = '0;
    if (wr_out_vld) commit_mask[wr_out.row] = 1'b1;
  end

  // Commit the write leaving the pipe; reset zeroes the whole store.
  always_ff @(posedge clk) begin
    if (!rst_n)          mem <= '0;
    else if (wr_out_vld) mem[wr_out.row] <= wr_out.data;
  end

  // ---------------- read path ----------------
  logic                      rd_ok, rd_bad;
  logic [RIDX_W-1:0]         rd_idx;
  logic [MEM_PORT_WIDTH-1:0] rd_sample;

  assign rd_ok  = (rd_row < ROWS_LIM);
  assign rd_bad = rd_en && !rd_ok;
  assign rd_idx = rd_row[RIDX_W-1:0];

  // Sample storage at request time; a same-cycle commit to the row wins.
  // Anything not a valid in-range read carries zero so rd_data idles at zero.
  always_comb begin
    rd_sample = '0;
    if (rd_en && rd_ok)
      rd_sample = (wr_out_vld && (wr_out.row == rd_idx)) ? wr_out.data : mem[rd_idx];
  end

  latency_pipe #(.STAGES(MEM_ACCESS_LATENCY), .W(MEM_PORT_WIDTH)) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_en),
    .in_data  (rd_sample),
    .out_vld  (rd_valid),
    .out_data (rd_data)
  );

  // ---------------- status ----------------
  // Bitmap and sticky errors; clear keeps a same-cycle commit and beats error sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_written <= '0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else if (clear) begin
      rows_written <= commit_mask;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      rows_written <= rows_written | commit_mask;
      wr_err       <= wr_err | wr_drop;
      rd_err       <= rd_err | rd_bad;
    end
  end

  assign all_rows_done = &rows_written;

endmodule
